// File: rtl/counter_pkg.sv
// Shared constants and helpers for the loadable up-counter.
// Holds the default width and the all-ones maximum count helper.
package counter_pkg;

  localparam int DEFAULT_WIDTH = 8;

  // Largest value a w-bit counter holds (2^w - 1), valid for w in 1..32.
  function automatic logic [31:0] max_count(input int unsigned w);
    return 32'hFFFF_FFFF >> (32 - w);
  endfunction

endpackage

// File: rtl/counter.sv
// Loadable up-counter with a registered one-cycle wrap flag.
// Define COUNTER_ASSERT_EN to compile in concurrent protocol checks.
module counter
  import counter_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             enable,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  output logic [WIDTH-1:0] count,
  output logic             overflow
);

  localparam logic [WIDTH-1:0] MAX_CNT = WIDTH'(max_count(WIDTH));

  logic [WIDTH-1:0] r_count;
  logic             r_overflow;
  logic             w_at_max;

  // Wrap happens only when an increment leaves the all-ones value.
  always_comb w_at_max = (r_count == MAX_CNT);

  // Count register: load beats increment beats hold; flag marks wraps.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count    <= '0;
      r_overflow <= 1'b0;
    end else if (load) begin
      r_count    <= load_value;
      r_overflow <= 1'b0;
    end else if (enable) begin
      r_count    <= r_count + 1'b1;
      r_overflow <= w_at_max;
    end else begin
      r_overflow <= 1'b0;
    end
  end

  assign count    = r_count;
  assign overflow = r_overflow;

`ifdef COUNTER_ASSERT_EN
  a_load : assert property (
    @(posedge clk) disable iff (!rst_n)
    load |=> (count == $past(load_value))
  );

  a_incr : assert property (
    @(posedge clk) disable iff (!rst_n)
    (!load && enable) |=>
      (count == WIDTH'($past(count) + 1'b1))
  );

  a_hold : assert property (
    @(posedge clk) disable iff (!rst_n)
    (!load && !enable) |=> (count == $past(count))
  );

  a_ovf_pulse : assert property (
    @(posedge clk) disable iff (!rst_n)
    overflow |=> !overflow
  );

  a_no_x : assert property (
    @(posedge clk) disable iff (!rst_n)
    !$isunknown({count, overflow})
  );
`endif

endmodule

// File: tb/tb_counter.sv
// Self-checking bench for counter: directed scenarios then random
// traffic, compared against an arithmetic reference model.
module tb_counter;

  localparam int W = 8;
  localparam int MOD = 256;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         enable;
  logic         load;
  logic [W-1:0] load_value;
  logic [W-1:0] count;
  logic         overflow;

  int checks = 0;
  int errors = 0;

  int m_count = 0;
  int m_ovf = 0;

  counter #(.WIDTH(W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .enable     (enable),
    .load       (load),
    .load_value (load_value),
    .count      (count),
    .overflow   (overflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference model: one clock edge of the counter's rules.
  task automatic model_edge(input bit ld, input bit en, input int lv);
    if (ld) begin
      m_count = lv;
      m_ovf = 0;
    end else if (en) begin
      m_ovf = (m_count == MOD - 1) ? 1 : 0;
      m_count = (m_count + 1) % MOD;
    end else begin
      m_ovf = 0;
    end
  endtask

  // Apply inputs, take one edge, then check both outputs vs model.
  task automatic step(input string tag, input bit ld,
                      input bit en, input int lv);
    load = ld;
    enable = en;
    load_value = W'(lv);
    @(posedge clk);
    model_edge(ld, en, lv);
    #1;
    chk({tag, ".count"}, {24'b0, count}, m_count);
    chk({tag, ".ovf"}, {31'b0, overflow}, m_ovf);
  endtask

  initial begin
    rst_n = 1'b0;
    enable = 1'b0;
    load = 1'b0;
    load_value = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst.count", {24'b0, count}, 0);
    chk("rst.ovf", {31'b0, overflow}, 0);
    rst_n = 1'b1;

    // Load while disabled, then hold.
    step("s1.load", 1, 0, 42);
    chk("s1.lit", {24'b0, count}, 42);
    step("s1.hold", 0, 0, 7);
    step("s1.hold2", 0, 0, 9);
    chk("s1.held", {24'b0, count}, 42);

    // Load while enabled; increments resume next edge.
    for (int i = 0; i < 5; i++) step("s2.inc", 0, 1, 0);
    chk("s2.pre", {24'b0, count}, 47);
    step("s2.load", 1, 1, 100);
    chk("s2.lit100", {24'b0, count}, 100);
    step("s2.resume", 0, 1, 0);
    chk("s2.lit101", {24'b0, count}, 101);

    // Back-to-back loads: last wins.
    step("s3.ld200", 1, 1, 200);
    step("s3.ld150", 1, 1, 150);
    chk("s3.lit150", {24'b0, count}, 150);
    step("s3.inc", 0, 1, 0);
    chk("s3.lit151", {24'b0, count}, 151);

    // Boundary loads never raise overflow.
    step("s4.ld255", 1, 0, 255);
    chk("s4.lit255", {24'b0, count}, 255);
    step("s4.ld0", 1, 0, 0);
    chk("s4.lit0", {24'b0, count}, 0);
    chk("s4.ovf", {31'b0, overflow}, 0);
    step("s4.ld255b", 1, 1, 255);
    step("s4.ld0en", 1, 1, 0);
    chk("s4.ovf_en", {31'b0, overflow}, 0);

    // Wrap pulse lasts exactly one cycle.
    step("s5.ld254", 1, 0, 254);
    step("s5.to255", 0, 1, 0);
    chk("s5.lit255", {24'b0, count}, 255);
    chk("s5.ovf0", {31'b0, overflow}, 0);
    step("s5.wrap", 0, 1, 0);
    chk("s5.lit0", {24'b0, count}, 0);
    chk("s5.ovf1", {31'b0, overflow}, 1);
    step("s5.after", 0, 1, 0);
    chk("s5.lit1", {24'b0, count}, 1);
    chk("s5.ovf_clr", {31'b0, overflow}, 0);

    // Wrap then a load edge clears overflow.
    step("s5.ld255", 1, 0, 255);
    step("s5.wrap2", 0, 1, 0);
    chk("s5.ovf2", {31'b0, overflow}, 1);
    step("s5.ldclr", 1, 1, 255);
    chk("s5.ldclr_ovf", {31'b0, overflow}, 0);

    // Async reset mid-count, between edges.
    step("s6.ld250", 1, 0, 250);
    step("s6.inc", 0, 1, 0);
    #2;
    rst_n = 1'b0;
    #1;
    chk("s6.async.count", {24'b0, count}, 0);
    chk("s6.async.ovf", {31'b0, overflow}, 0);
    load = 1'b1;
    load_value = 8'd77;
    enable = 1'b1;
    repeat (3) begin
      @(posedge clk);
      #1;
      chk("s6.held.count", {24'b0, count}, 0);
      chk("s6.held.ovf", {31'b0, overflow}, 0);
    end
    rst_n = 1'b1;
    m_count = 0;
    m_ovf = 0;
    #2;
    chk("s6.rel", {24'b0, count}, 0);
    step("s6.first", 0, 1, 0);
    chk("s6.lit1", {24'b0, count}, 1);

    // Random traffic against the model.
    for (int i = 0; i < 400; i++) begin
      bit ld;
      bit en;
      int lv;
      ld = ($urandom_range(0, 7) == 0);
      en = ($urandom_range(0, 3) != 0);
      lv = $urandom_range(0, MOD - 1);
      if ($urandom_range(0, 3) == 0) lv = MOD - 2 + $urandom_range(0, 1);
      step("rnd", ld, en, lv);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed running expected finished");
    $fatal(1, "timeout");
  end

endmodule
